// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver with a shadow/active
// register pair so new data only takes effect at frame boundaries.
module seven_segment_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [TW-1:0]         tick_reg;
  logic [IW-1:0]         idx_reg;
  logic [4*DIGITS-1:0]   shadow_value_reg;
  logic [DIGITS-1:0]     shadow_dp_reg;
  logic [DIGITS-1:0]     shadow_blank_reg;
  logic                  shadow_lz_reg;
  logic [4*DIGITS-1:0]   active_value_reg;
  logic [DIGITS-1:0]     active_dp_reg;
  logic [DIGITS-1:0]     active_blank_reg;
  logic                  active_lz_reg;

  logic                  tick_wrap;
  logic                  frame_wrap;
  logic [DIGITS-1:0]     digit_zero;
  logic [DIGITS-1:0]     lz_dark;
  logic [6:0]            digit_seg [DIGITS];
  logic [DIGITS-1:0]     digit_dp;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [DIGITS-1:0]     an_next;

  assign tick_wrap  = (tick_reg == TICK_LAST);
  assign frame_wrap = tick_wrap && (idx_reg == IDX_LAST);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg <= '0;
      idx_reg  <= '0;
    end else if (tick_wrap) begin
      tick_reg <= '0;
      idx_reg  <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end else begin
      tick_reg <= tick_reg + 1'b1;
    end
  end

  // A load on the wrap edge still lets the previous shadow commit; the new
  // data stays pending for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value_reg <= '0;
      shadow_dp_reg    <= '0;
      shadow_blank_reg <= '0;
      shadow_lz_reg    <= 1'b0;
      pending          <= 1'b0;
      active_value_reg <= '0;
      active_dp_reg    <= '0;
      active_blank_reg <= '1;
      active_lz_reg    <= 1'b0;
    end else begin
      if (frame_wrap && pending) begin
        active_value_reg <= shadow_value_reg;
        active_dp_reg    <= shadow_dp_reg;
        active_blank_reg <= shadow_blank_reg;
        active_lz_reg    <= shadow_lz_reg;
      end
      if (load) begin
        shadow_value_reg <= value;
        shadow_dp_reg    <= dp_in;
        shadow_blank_reg <= blank_in;
        shadow_lz_reg    <= lz_en;
        pending          <= 1'b1;
      end else if (frame_wrap) begin
        pending <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign digit_zero[gi] = (active_value_reg[4*gi +: 4] == 4'h0);
    assign digit_seg[gi]  = (active_blank_reg[gi] || lz_dark[gi]) ? 7'h7F
                          : hex_to_seg(active_value_reg[4*gi +: 4]);
    assign digit_dp[gi]   = active_blank_reg[gi] ? 1'b1 : ~active_dp_reg[gi];
  end

  // Walk from the most significant digit down; a zero is only "leading"
  // while everything above it is zero or blanked. Digit 0 always shows.
  always_comb begin
    logic above_clear;
    above_clear = 1'b1;
    lz_dark     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_dark[i]  = active_lz_reg && (i != 0) && digit_zero[i] && above_clear;
      above_clear = above_clear && (digit_zero[i] || active_blank_reg[i]);
    end
  end

  always_comb begin
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    an_next  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_reg == IW'(i)) begin
        seg_next = digit_seg[i];
        dp_next  = digit_dp[i];
        if (!tick_wrap) begin
          an_next[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next;
      dp         <= dp_next;
      an         <= an_next;
      frame_done <= frame_wrap;
    end
  end

endmodule
